// File: rtl/aes_key_unroll.sv
// aes_key_unroll
//   Reverse AES-128 round-key sequencer for the decryption datapath. A loaded
//   cipher key is expanded forward to the round-10 key, which is kept. On
//   request, round keys 10 down to 0 are streamed over a valid/accept handshake,
//   each one regenerated from the previous by the inverse key-schedule step.
//   Because of this, no 11-entry round-key store is needed.
//
//   Ports
//     clk          in   1    clock, rising edge
//     reset        in   1    asynchronous, active-high
//     key_in       in   128  cipher key, word 0 = bits [127:96]
//     key_load     in   1    pulse: sample key_in and start forward expansion
//     busy         out  1    forward expansion in progress
//     key_ready    out  1    round-10 key held, idle, able to stream
//     rk_start     in   1    pulse: start a reverse stream (only when key_ready)
//     rk_out       out  128  current round key
//     rk_round     out  4    round index of rk_out (10..0)
//     rk_valid     out  1    rk_out / rk_round valid
//     rk_accept    in   1    consumer takes the beat when rk_valid & rk_accept
//     rk_last      out  1    high with the round-0 beat
//     key_mismatch out  1    sticky recovered-key check failure
//
//   Build option
//     AES_KEY_UNROLL_VERIFY_EN : keep a copy of the loaded cipher key and
//     compare it with the accepted round-0 beat. Without it, key_mismatch is 0.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no key loaded since reset
//   EXPAND  | one forward key-schedule round per cycle, rounds 1..10
//   HOLD    | round-10 key kept in last_key_q, ready to stream
//   STREAM  | presenting round keys 10..0, stepping back on each accept

module aes_key_unroll (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         busy,
  output logic         key_ready,
  input  logic         rk_start,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_accept,
  output logic         rk_last,
  output logic         key_mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_HOLD   = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;        // working round key
  logic [127:0]   last_key_q, last_key_d;
  logic [3:0]     rnd_q, rnd_d;        // forward counter in EXPAND, rk_round in STREAM

  // ---------------------------------------------------------------------------
  // Shared key-schedule datapath
  // ---------------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sb_src, sb_in, sb_out, sched_t;
  logic [31:0]  fwd0, fwd1, fwd2, fwd3;
  logic [31:0]  inv0, inv1, inv2, inv3;
  logic [127:0] fwd_key, inv_key;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Inverse step recovers the previous w3 first (c3^c2); the S-box then runs
  // on that word, so one set of four S-box lookups serves both directions.
  assign inv3 = w3 ^ w2;
  assign inv2 = w2 ^ w1;
  assign inv1 = w1 ^ w0;

  assign sb_src  = (state_q == ST_STREAM) ? inv3 : w3;
  assign sb_in   = {sb_src[23:0], sb_src[31:24]};
  assign sb_out  = sub_word(sb_in);
  assign sched_t = sb_out ^ {rcon(rnd_q), 24'h000000};

  assign fwd0 = w0 ^ sched_t;
  assign fwd1 = w1 ^ fwd0;
  assign fwd2 = w2 ^ fwd1;
  assign fwd3 = w3 ^ fwd2;
  assign inv0 = w0 ^ sched_t;

  assign fwd_key = {fwd0, fwd1, fwd2, fwd3};
  assign inv_key = {inv0, inv1, inv2, inv3};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      last_key_q <= '0;
      rnd_q      <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      last_key_q <= last_key_d;
      rnd_q      <= rnd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    last_key_d = last_key_q;
    rnd_d      = rnd_q;

    if (key_load) begin
      // A load restarts expansion from any state and beats a same-cycle rk_start.
      state_d = ST_EXPAND;
      key_d   = key_in;
      rnd_d   = 4'd1;
    end else begin
      case (state_q)
        ST_EXPAND: begin
          key_d = fwd_key;
          if (rnd_q == 4'd10) begin
            state_d    = ST_HOLD;
            last_key_d = fwd_key;
            rnd_d      = 4'd0;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
        ST_HOLD: begin
          if (rk_start) begin
            state_d = ST_STREAM;
            key_d   = last_key_q;
            rnd_d   = 4'd10;
          end
        end
        ST_STREAM: begin
          if (rk_accept) begin
            if (rnd_q != 4'd0) begin
              key_d = inv_key;
              rnd_d = rnd_q - 4'd1;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state so reset clears them at once)
  // ---------------------------------------------------------------------------
  assign busy      = (state_q == ST_EXPAND);
  assign key_ready = (state_q == ST_HOLD);
  assign rk_valid  = (state_q == ST_STREAM);
  assign rk_out    = rk_valid ? key_q : '0;
  assign rk_round  = rk_valid ? rnd_q : 4'd0;
  assign rk_last   = rk_valid && (rnd_q == 4'd0);

  // ---------------------------------------------------------------------------
  // Optional recovered-key check
  // ---------------------------------------------------------------------------
`ifdef AES_KEY_UNROLL_VERIFY_EN
  logic [127:0] orig_key_q, orig_key_d;
  logic         mismatch_q, mismatch_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      orig_key_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      orig_key_q <= orig_key_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    orig_key_d = orig_key_q;
    mismatch_d = mismatch_q;
    if (key_load) begin
      orig_key_d = key_in;
      mismatch_d = 1'b0;
    end else if (rk_last && rk_accept && (key_q != orig_key_q)) begin
      mismatch_d = 1'b1;
    end
  end

  assign key_mismatch = mismatch_q;
`else
  assign key_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_unroll.sv
module tb_aes_key_unroll;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic         key_ready;
  logic         rk_start;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_accept;
  logic         rk_last;
  logic         key_mismatch;

  aes_key_unroll dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .key_load     (key_load),
    .busy         (busy),
    .key_ready    (key_ready),
    .rk_start     (rk_start),
    .rk_out       (rk_out),
    .rk_round     (rk_round),
    .rk_valid     (rk_valid),
    .rk_accept    (rk_accept),
    .rk_last      (rk_last),
    .key_mismatch (key_mismatch)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [127:0] key;
    int           rnd;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic         last;
  } beat_t;

  int           n_cmp = 0;
  int           n_bad = 0;
  vec_t         vecs[7];
  beat_t        sbq[$];
  logic [7:0]   sb_m[256];
  logic [127:0] model_rk[11];
  logic [127:0] cap[11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference S-box built from the GF(2^8) inverse and the affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] m_subw(input logic [31:0] w);
    return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
  endfunction

  // Forward expansion of all 11 round keys.
  task automatic model_expand(input logic [127:0] k);
    logic [7:0]  rc = 8'h01;
    logic [31:0] a, b, c, d, t;
    model_rk[0] = k;
    for (int i = 1; i <= 10; i++) begin
      {a, b, c, d} = model_rk[i-1];
      t = m_subw({d[23:0], d[31:24]}) ^ {rc, 24'h0};
      a = a ^ t;
      b = b ^ a;
      c = c ^ b;
      d = d ^ c;
      model_rk[i] = {a, b, c, d};
      rc = xtime(rc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    model_expand(k);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (busy && n < 30) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, 128'(n), 128'd10);
    check({tag, "_key_ready"}, {127'd0, key_ready}, 128'd1);
  endtask

  // Streams rounds 10..0; abort_after >= 0 stops after that many accepted beats.
  task automatic run_stream(input string tag, input bit rand_acc, input int abort_after);
    int cyc = 0;
    int beats = 0;
    bit acc;
    beat_t e;
    for (int i = 0; i < 11; i++) cap[i] = '0;
    for (int r = 10; r >= 0; r--) begin
      e.rnd  = 4'(r);
      e.key  = model_rk[r];
      e.last = (r == 0);
      sbq.push_back(e);
    end
    rk_start = 1'b1;
    tick();
    rk_start = 1'b0;
    while (sbq.size() > 0 && cyc < 300 && !(abort_after >= 0 && beats == abort_after)) begin
      cyc++;
      check({tag, "_rk_valid"}, {127'd0, rk_valid}, 128'd1);
      if (!rk_valid) break;
      e = sbq[0];
      check({tag, "_rk_round"}, {124'd0, rk_round}, {124'd0, e.rnd});
      check({tag, "_rk_out"}, rk_out, e.key);
      check({tag, "_rk_last"}, {127'd0, rk_last}, {127'd0, e.last});
      acc = rand_acc ? ($urandom_range(0, 2) != 0) : 1'b1;
      rk_accept = acc;
      if (acc) cap[e.rnd] = rk_out;
      tick();
      if (acc) begin
        void'(sbq.pop_front());
        beats++;
      end
    end
    rk_accept = 1'b0;
    if (abort_after < 0) begin
      check({tag, "_drained"}, 128'(sbq.size()), 128'd0);
      check({tag, "_ready_after"}, {127'd0, key_ready}, 128'd1);
      check({tag, "_key_mismatch"}, {127'd0, key_mismatch}, 128'd0);
    end
  endtask

  task automatic apply_table(input string tag, input logic [127:0] k);
    for (int i = 0; i < 7; i++)
      if (vecs[i].key == k)
        check($sformatf("%s_vec%0d_round%0d", tag, i, vecs[i].rnd), cap[vecs[i].rnd], vecs[i].exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {127'd0, busy}, 128'd0);
    check({tag, "_key_ready"}, {127'd0, key_ready}, 128'd0);
    check({tag, "_rk_valid"}, {127'd0, rk_valid}, 128'd0);
    check({tag, "_rk_last"}, {127'd0, rk_last}, 128'd0);
    check({tag, "_key_mismatch"}, {127'd0, key_mismatch}, 128'd0);
    check({tag, "_rk_out"}, rk_out, 128'd0);
    check({tag, "_rk_round"}, {124'd0, rk_round}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{KEY_A, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{KEY_A, 9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[2] = '{KEY_A, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[3] = '{KEY_A, 0,  KEY_A};
    vecs[4] = '{KEY_B, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[5] = '{KEY_B, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[6] = '{KEY_B, 0,  KEY_B};

    reset     = 1'b1;
    key_in    = '0;
    key_load  = 1'b0;
    rk_start  = 1'b0;
    rk_accept = 1'b0;
    build_sbox();
    tick();
    tick();
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();

    // rk_start with no key loaded is ignored
    rk_start = 1'b1;
    tick();
    rk_start = 1'b0;
    check("idle_start_ignored", {127'd0, rk_valid}, 128'd0);

    // Expansion latency and full-rate stream of key A
    load_key(KEY_A);
    wait_ready("expand_a");
    rk_accept = 1'b1;
    tick();
    tick();
    rk_accept = 1'b0;
    check("accept_no_valid_ready", {127'd0, key_ready}, 128'd1);
    check("accept_no_valid_valid", {127'd0, rk_valid}, 128'd0);
    run_stream("full_a", 1'b0, -1);
    apply_table("full_a", KEY_A);

    // Random back-pressure, then a repeat without reloading
    run_stream("stall_a", 1'b1, -1);
    apply_table("stall_a", KEY_A);
    run_stream("repeat_a", 1'b0, -1);
    apply_table("repeat_a", KEY_A);

    // key_load mid-stream aborts and restarts expansion
    run_stream("abort_a", 1'b0, 4);
    check("abort_still_valid", {127'd0, rk_valid}, 128'd1);
    load_key(KEY_B);
    sbq.delete();
    check("abort_valid_drop", {127'd0, rk_valid}, 128'd0);
    check("abort_busy", {127'd0, busy}, 128'd1);
    wait_ready("expand_b");
    run_stream("full_b", 1'b0, -1);
    apply_table("full_b", KEY_B);

    // key_load and rk_start together in HOLD: the load wins
    key_in   = KEY_A;
    key_load = 1'b1;
    rk_start = 1'b1;
    tick();
    key_load = 1'b0;
    rk_start = 1'b0;
    model_expand(KEY_A);
    check("load_wins_busy", {127'd0, busy}, 128'd1);
    check("load_wins_valid", {127'd0, rk_valid}, 128'd0);
    wait_ready("expand_a2");
    run_stream("stall_a2", 1'b1, -1);
    apply_table("stall_a2", KEY_A);

    // Reset mid-expansion clears outputs asynchronously
    load_key(KEY_B);
    tick();
    tick();
    check("pre_reset_busy", {127'd0, busy}, 128'd1);
    reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    tick();
    reset = 1'b0;
    tick();
    rk_start = 1'b1;
    tick();
    rk_start = 1'b0;
    check("post_reset_start_valid", {127'd0, rk_valid}, 128'd0);
    check("post_reset_key_ready", {127'd0, key_ready}, 128'd0);
    load_key(KEY_B);
    wait_ready("expand_b2");
    run_stream("full_b2", 1'b0, -1);
    apply_table("full_b2", KEY_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_key_unroll.md
# aes_key_unroll

Reverse AES-128 round-key sequencer for the decryption datapath. It takes a cipher key and expands it forward to the round-10 key. On request, it then streams round keys in reverse order, 10 down to 0, over a valid/accept handshake, regenerating each one with the inverse key-schedule step. It sits between the host key port and the decryption core, so no 11-entry round-key store is needed.

## Interface
Parameters:
- none (AES-128 only; Nk=4, Nr=10 fixed)

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `key_in`  in  128  cipher key; word 0 = bits [127:96].
- `key_load`  in  1  one-cycle pulse; samples `key_in`, starts forward expansion.
- `busy`  out  1  high during forward expansion.
- `key_ready`  out  1  round-10 key held, block idle and able to stream.
- `rk_start`  in  1  pulse; begins a reverse stream (honoured only when `key_ready`=1).
- `rk_out`  out  128  current round key.
- `rk_round`  out  4  round index of `rk_out` (10..0).
- `rk_valid`  out  1  `rk_out`/`rk_round` valid.
- `rk_accept`  in  1  consumer takes the beat when `rk_valid`&`rk_accept`.
- `rk_last`  out  1  high with the round-0 beat.
- `key_mismatch`  out  1  sticky recovered-key check failure (see Configuration).

## Operation
- FSM states: IDLE, EXPAND, HOLD, STREAM.
- IDLE:
  - `key_load` → EXPAND; working reg ← `key_in`; round ctr ← 1.
- EXPAND:
  - one forward round per cycle, using standard RotWord/SubWord/Rcon.
  - After ctr=10 completes → HOLD, with the round-10 key stored in `last_key`.
- HOLD:
  - `key_ready`=1.
  - `rk_start` → STREAM; working reg ← `last_key`; `rk_round` ← 10.
- STREAM:
  - `rk_valid`=1; data holds stable until accepted.
  - On accept with `rk_round`≠0: `rk_round` decrements and the working reg takes the inverse step:
    - p3=c3^c2, p2=c2^c1, p1=c1^c0.
    - p0=c0^SubWord(RotWord(p3))^Rcon[r], where r is the current `rk_round`.
  - On accept with `rk_round`=0 (`rk_last`=1) → HOLD. `last_key` is retained, so streams are repeatable without reloading.
- `key_load` in any state other than IDLE aborts the current activity and restarts EXPAND with the new key.
  - A `key_load` and `rk_start` in the same cycle: `key_load` wins.
- `rk_start` outside HOLD is ignored.
- `rk_accept` without `rk_valid` is ignored.
- SubWord uses a combinational S-box (4 instances, shared between forward and inverse steps). Rcon is a 10-entry constant table: 01,02,04,08,10,20,40,80,1b,36.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `key_ready`, `rk_valid`, `rk_last`, `key_mismatch` = 0.
  - `rk_out`, `rk_round` = 0.
- `key_load` sampled at edge T → `busy`=1 from T+1 through T+10 → `key_ready`=1 at T+11.
- `rk_start` sampled in HOLD at edge S → `rk_valid`=1 with round 10 at S+1.
- Sustained `rk_accept`=1 delivers one key per cycle: 11 beats, rounds 10..0, over cycles S+1..S+11. `key_ready`=1 again at S+12.
- Back-pressure: with `rk_accept`=0, `rk_out`/`rk_round` hold indefinitely.
- `reset` mid-EXPAND or mid-STREAM: outputs clear asynchronously. `key_ready` stays 0 until a new `key_load` completes.

## Configuration
- `AES_KEY_UNROLL_VERIFY_EN`:
  - Defined: the block keeps a 128-bit copy of the loaded cipher key. On the accepted round-0 beat, `rk_out` is compared with that copy. A mismatch sets `key_mismatch`, which stays set until the next `key_load` or `reset`.
  - Undefined: no copy register is built and `key_mismatch` is tied 0.

## Test plan
- Reset, then `key_load` with key 2b7e151628aed2a6abf7158809cf4f3c → `busy` for 10 cycles, `key_ready` at T+11.
- `rk_start` with `rk_accept`=1 throughout → round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = the key, with `rk_last`=1; `key_mismatch`=0.
- Random `rk_accept` stalls → `rk_out` stable while stalled; 11 beats in order 10..0, none dropped or duplicated.
- Second `rk_start` without reload → identical 11-key sequence.
- `key_load` of key 000102030405060708090a0b0c0d0e0f mid-STREAM → `rk_valid` drops next cycle and expansion restarts. The new stream's round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- `reset` asserted mid-EXPAND → all outputs 0 immediately; `rk_start` ignored until a fresh `key_load` completes.
